axi_slave: RTL and testbench

AXI4-Lite responder that terminates the bus write and read channels on a peripheral. It converts each accepted transaction into a simple single-cycle request toward a register/peripheral back end, and returns the AXI response.
- Supports one outstanding transaction per direction.
- Read and write paths are fully independent.
- Includes address-window decode (DECERR) and a back-end timeout (SLVERR).
- Sits between the interconnect and each memory-mapped peripheral.

---
 rtl/axi_slave_pkg.sv | 39 +++
 rtl/axi_slave_if.sv | 41 ++++
 rtl/axi_slave_timeout_counter.sv | 37 +++
 rtl/axi_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_slave.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_slave_pkg.sv
// Shared AXI4-Lite response encoding, FSM state types and address-window helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package axi_slave_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_response_t;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_ISSUE = 2'd1,
        W_WAIT  = 2'd2,
        W_RESP  = 2'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ISSUE = 2'd1,
        R_WAIT  = 2'd2,
        R_RESP  = 2'd3
    } r_state_t;

    // Offset wraps modulo 2^32, so an address below the base becomes a huge
    // offset and fails the single unsigned compare in window_hit().
    function automatic logic [31:0] window_offset(input logic [31:0] addr,
                                                  input logic [31:0] base);
        return addr - base;
    endfunction

    function automatic logic window_hit(input logic [31:0] offset,
                                        input logic [31:0] size);
        return offset < size;
    endfunction

endpackage

// File: rtl/axi_slave_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) between interconnect and slave.
// Latency: n/a (wires only).
// Backpressure: standard VALID/READY on every channel.
interface axi_slave_if;
    import axi_slave_pkg::*;

    logic [31:0]   AWADDR;
    logic          AWVALID;
    logic          AWREADY;
    logic [31:0]   WDATA;
    logic [3:0]    WSTRB;
    logic          WVALID;
    logic          WREADY;
    axi_response_t BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [31:0]   ARADDR;
    logic          ARVALID;
    logic          ARREADY;
    logic [31:0]   RDATA;
    axi_response_t RRESP;
    logic          RVALID;
    logic          RREADY;

    modport slave (
        input  AWADDR, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input  ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY
    );

endinterface

// File: rtl/axi_slave_timeout_counter.sv
// Saturating wait-cycle counter; flags expiry on the TIMEOUT_CYCLES-th enabled cycle.
// Latency: o_expired is combinational from the count and i_en.
// Backpressure: none; TIMEOUT_CYCLES = 0 disables expiry entirely.
// Ports: clk_i/rst_i clock and async reset, i_clear zeroes the count,
//        i_en counts one wait cycle, o_expired marks the final allowed cycle.
module axi_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit ENABLED = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT_M1 = ENABLED ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The count holds the number of wait cycles already finished, so the
    // current cycle is the last allowed one when it equals LIMIT-1.
    assign o_expired = ENABLED && i_en && (r_count >= LIMIT_M1);

endmodule

// File: rtl/axi_slave.sv
// AXI4-Lite slave: converts each AW+W or AR transaction into a one-cycle back-end request.
// Latency: handshake -> request 1 cycle, back-end done -> B/R VALID 1 cycle; decode errors answer 1 cycle after handshake.
// Backpressure: one outstanding transaction per direction; READYs stay low until B/R handshake completes.
// Ports: clk_i/rst_i, s_axi (AXI4-Lite slave modport), write_* back-end write
//        payload/handshake, read_* back-end read request/return.
module axi_slave
    import axi_slave_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE      = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    axi_slave_if.slave  s_axi,
    output logic [31:0] write_address_o,
    output logic [31:0] write_data_o,
    output logic [3:0]  write_strobe_o,
    output logic        write_request_o,
    input  logic        write_done_i,
    input  logic        write_error_i,
    output logic [31:0] read_address_o,
    output logic        read_request_o,
    input  logic [31:0] read_data_i,
    input  logic        read_done_i,
    input  logic        read_error_i
);

    // ---------------- write path ----------------
    w_state_t      r_wstate;
    logic          r_aw_got;
    logic          r_w_got;
    logic [31:0]   r_waddr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic          r_wreq;
    logic          r_bvalid;
    axi_response_t r_bresp;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_aw_have;
    logic        w_w_have;
    logic [31:0] w_aw_off;
    logic [31:0] w_wr_off;
    logic        w_wr_hit;
    logic        w_wr_expired;

    assign s_axi.AWREADY = !rst_i && (r_wstate == W_IDLE) && !r_aw_got;
    assign s_axi.WREADY  = !rst_i && (r_wstate == W_IDLE) && !r_w_got;

    assign w_aw_hs   = s_axi.AWVALID && s_axi.AWREADY;
    assign w_w_hs    = s_axi.WVALID && s_axi.WREADY;
    // Look at this cycle's handshakes too, so the request can go out on the
    // cycle right after the last of AW/W arrives.
    assign w_aw_have = r_aw_got || w_aw_hs;
    assign w_w_have  = r_w_got || w_w_hs;
    assign w_aw_off  = window_offset(s_axi.AWADDR, ADDR_BASE);
    assign w_wr_off  = w_aw_hs ? w_aw_off : r_waddr;
    assign w_wr_hit  = window_hit(w_wr_off, ADDR_SIZE);

    axi_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_clear   (r_wstate == W_ISSUE),
        .i_en      (r_wstate == W_WAIT),
        .o_expired (w_wr_expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wstate <= W_IDLE;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_wreq   <= 1'b0;
            r_bvalid <= 1'b0;
            r_bresp  <= OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_got <= 1'b1;
                        r_waddr  <= w_aw_off;
                    end
                    if (w_w_hs) begin
                        r_w_got <= 1'b1;
                        r_wdata <= s_axi.WDATA;
                        r_wstrb <= s_axi.WSTRB;
                    end
                    if (w_aw_have && w_w_have) begin
                        if (w_wr_hit) begin
                            r_wstate <= W_ISSUE;
                            r_wreq   <= 1'b1;
                        end else begin
                            r_wstate <= W_RESP;
                            r_bvalid <= 1'b1;
                            r_bresp  <= DECERR;
                        end
                    end
                end
                W_ISSUE: begin
                    r_wreq   <= 1'b0;
                    r_wstate <= W_WAIT;
                end
                W_WAIT: begin
                    // done outranks a simultaneous timeout
                    if (write_done_i) begin
                        r_bresp  <= write_error_i ? SLVERR : OKAY;
                        r_bvalid <= 1'b1;
                        r_wstate <= W_RESP;
                    end else if (w_wr_expired) begin
                        r_bresp  <= SLVERR;
                        r_bvalid <= 1'b1;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi.BREADY) begin
                        r_bvalid <= 1'b0;
                        r_aw_got <= 1'b0;
                        r_w_got  <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign write_address_o = r_waddr;
    assign write_data_o    = r_wdata;
    assign write_strobe_o  = r_wstrb;
    assign write_request_o = r_wreq;
    assign s_axi.BVALID    = r_bvalid;
    assign s_axi.BRESP     = r_bresp;

    // ---------------- read path ----------------
    r_state_t      r_rstate;
    logic [31:0]   r_raddr;
    logic          r_rreq;
    logic          r_rvalid;
    logic [31:0]   r_rdata;
    axi_response_t r_rresp;

    logic        w_ar_hs;
    logic [31:0] w_ar_off;
    logic        w_rd_expired;

    assign s_axi.ARREADY = !rst_i && (r_rstate == R_IDLE);
    assign w_ar_hs       = s_axi.ARVALID && s_axi.ARREADY;
    assign w_ar_off      = window_offset(s_axi.ARADDR, ADDR_BASE);

    axi_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_clear   (r_rstate == R_ISSUE),
        .i_en      (r_rstate == R_WAIT),
        .o_expired (w_rd_expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rstate <= R_IDLE;
            r_raddr  <= '0;
            r_rreq   <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_raddr <= w_ar_off;
                        if (window_hit(w_ar_off, ADDR_SIZE)) begin
                            r_rstate <= R_ISSUE;
                            r_rreq   <= 1'b1;
                        end else begin
                            r_rstate <= R_RESP;
                            r_rvalid <= 1'b1;
                            r_rresp  <= DECERR;
                            r_rdata  <= '0;
                        end
                    end
                end
                R_ISSUE: begin
                    r_rreq   <= 1'b0;
                    r_rstate <= R_WAIT;
                end
                R_WAIT: begin
                    if (read_done_i) begin
                        r_rdata  <= read_data_i;
                        r_rresp  <= read_error_i ? SLVERR : OKAY;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_RESP;
                    end else if (w_rd_expired) begin
                        r_rdata  <= '0;
                        r_rresp  <= SLVERR;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axi.RREADY) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign read_address_o = r_raddr;
    assign read_request_o = r_rreq;
    assign s_axi.RVALID   = r_rvalid;
    assign s_axi.RDATA    = r_rdata;
    assign s_axi.RRESP    = r_rresp;

endmodule

// File: tb/tb_axi_slave.sv
// Directed bench for axi_slave: window base 0x1000_0000, 4 KiB window, 16-cycle timeout.
// Latency: inputs driven 1 time unit after each rising edge, outputs checked at the same point.
// Backpressure: BREADY/RREADY held low for several cycles to check response holding.
module tb_axi_slave;
    import axi_slave_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] write_address_o;
    logic [31:0] write_data_o;
    logic [3:0]  write_strobe_o;
    logic        write_request_o;
    logic        write_done_i;
    logic        write_error_i;
    logic [31:0] read_address_o;
    logic        read_request_o;
    logic [31:0] read_data_i;
    logic        read_done_i;
    logic        read_error_i;

    int total = 0;
    int bad   = 0;
    int wreq_cnt = 0;
    int rreq_cnt = 0;
    int bvalid_cnt = 0;
    int bv_snap;

    axi_slave_if s_axi ();

    axi_slave #(
        .ADDR_BASE     (32'h1000_0000),
        .ADDR_SIZE     (32'h0000_1000),
        .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .s_axi          (s_axi),
        .write_address_o(write_address_o),
        .write_data_o   (write_data_o),
        .write_strobe_o (write_strobe_o),
        .write_request_o(write_request_o),
        .write_done_i   (write_done_i),
        .write_error_i  (write_error_i),
        .read_address_o (read_address_o),
        .read_request_o (read_request_o),
        .read_data_i    (read_data_i),
        .read_done_i    (read_done_i),
        .read_error_i   (read_error_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (write_request_o) wreq_cnt <= wreq_cnt + 1;
        if (read_request_o)  rreq_cnt <= rreq_cnt + 1;
        if (s_axi.BVALID)    bvalid_cnt <= bvalid_cnt + 1;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        s_axi.AWADDR = '0; s_axi.AWVALID = 1'b0;
        s_axi.WDATA = '0; s_axi.WSTRB = '0; s_axi.WVALID = 1'b0;
        s_axi.BREADY = 1'b0;
        s_axi.ARADDR = '0; s_axi.ARVALID = 1'b0;
        s_axi.RREADY = 1'b0;
        write_done_i = 1'b0; write_error_i = 1'b0;
        read_data_i = '0; read_done_i = 1'b0; read_error_i = 1'b0;

        // ---- reset state ----
        tick();
        check("rst_awready", 32'(s_axi.AWREADY), 32'd0);
        check("rst_wready",  32'(s_axi.WREADY),  32'd0);
        check("rst_arready", 32'(s_axi.ARREADY), 32'd0);
        check("rst_bvalid",  32'(s_axi.BVALID),  32'd0);
        check("rst_rvalid",  32'(s_axi.RVALID),  32'd0);
        check("rst_bresp",   32'(s_axi.BRESP),   32'(OKAY));
        check("rst_rresp",   32'(s_axi.RRESP),   32'(OKAY));
        check("rst_rdata",   s_axi.RDATA,        32'd0);
        check("rst_wreq",    32'(write_request_o), 32'd0);
        check("rst_rreq",    32'(read_request_o),  32'd0);
        rst_i = 1'b0;
        tick();
        check("idle_awready", 32'(s_axi.AWREADY), 32'd1);
        check("idle_wready",  32'(s_axi.WREADY),  32'd1);
        check("idle_arready", 32'(s_axi.ARREADY), 32'd1);

        // ---- write offset 0x4, AW and W together, done 2 cycles after request ----
        s_axi.AWADDR = 32'h1000_0004; s_axi.AWVALID = 1'b1;
        s_axi.WDATA = 32'hDEAD_BEEF; s_axi.WSTRB = 4'hF; s_axi.WVALID = 1'b1;
        tick();
        s_axi.AWVALID = 1'b0; s_axi.WVALID = 1'b0;
        check("w1_req",     32'(write_request_o), 32'd1);
        check("w1_addr",    write_address_o, 32'h0000_0004);
        check("w1_data",    write_data_o,    32'hDEAD_BEEF);
        check("w1_strb",    32'(write_strobe_o), 32'hF);
        check("w1_awready", 32'(s_axi.AWREADY), 32'd0);
        tick();
        check("w1_req_drop", 32'(write_request_o), 32'd0);
        tick();
        write_done_i = 1'b1;
        tick();
        write_done_i = 1'b0;
        check("w1_bvalid_c1", 32'(s_axi.BVALID), 32'd1);
        check("w1_bresp",     32'(s_axi.BRESP),  32'(OKAY));
        tick();
        check("w1_bvalid_c2", 32'(s_axi.BVALID), 32'd1);
        tick();
        check("w1_bvalid_c3", 32'(s_axi.BVALID), 32'd1);
        check("w1_bresp_hold", 32'(s_axi.BRESP), 32'(OKAY));
        s_axi.BREADY = 1'b1;
        tick();
        s_axi.BREADY = 1'b0;
        check("w1_bvalid_clr", 32'(s_axi.BVALID), 32'd0);
        check("w1_req_count",  32'(wreq_cnt), 32'd1);
        check("w1_addr_stable", write_address_o, 32'h0000_0004);

        // ---- W two cycles before AW; back end reports an error ----
        s_axi.WDATA = 32'h1122_3344; s_axi.WSTRB = 4'h3; s_axi.WVALID = 1'b1;
        tick();
        s_axi.WVALID = 1'b0;
        check("w2_wready_drop", 32'(s_axi.WREADY), 32'd0);
        check("w2_awready_c1",  32'(s_axi.AWREADY), 32'd1);
        check("w2_noreq_c1",    32'(write_request_o), 32'd0);
        tick();
        check("w2_awready_c2",  32'(s_axi.AWREADY), 32'd1);
        check("w2_noreq_c2",    32'(write_request_o), 32'd0);
        s_axi.AWADDR = 32'h1000_0008; s_axi.AWVALID = 1'b1;
        tick();
        s_axi.AWVALID = 1'b0;
        check("w2_req",  32'(write_request_o), 32'd1);
        check("w2_addr", write_address_o, 32'h0000_0008);
        check("w2_data", write_data_o, 32'h1122_3344);
        check("w2_strb", 32'(write_strobe_o), 32'h3);
        tick();
        write_done_i = 1'b1; write_error_i = 1'b1;
        tick();
        write_done_i = 1'b0; write_error_i = 1'b0;
        check("w2_bvalid", 32'(s_axi.BVALID), 32'd1);
        check("w2_bresp",  32'(s_axi.BRESP),  32'(SLVERR));
        s_axi.BREADY = 1'b1;
        tick();
        s_axi.BREADY = 1'b0;
        check("w2_req_count", 32'(wreq_cnt), 32'd2);

        // ---- decode errors: above the window and wrapped below the base ----
        s_axi.AWADDR = 32'h2000_0000; s_axi.AWVALID = 1'b1;
        s_axi.WDATA = 32'h0BAD_0BAD; s_axi.WSTRB = 4'hF; s_axi.WVALID = 1'b1;
        tick();
        s_axi.AWVALID = 1'b0; s_axi.WVALID = 1'b0;
        check("dec_w_bvalid", 32'(s_axi.BVALID), 32'd1);
        check("dec_w_bresp",  32'(s_axi.BRESP),  32'(DECERR));
        check("dec_w_noreq",  32'(write_request_o), 32'd0);
        s_axi.BREADY = 1'b1;
        tick();
        s_axi.BREADY = 1'b0;
        check("dec_w_req_count", 32'(wreq_cnt), 32'd2);
        s_axi.ARADDR = 32'h0FFF_FFFC; s_axi.ARVALID = 1'b1;
        tick();
        s_axi.ARVALID = 1'b0;
        check("dec_r_rvalid", 32'(s_axi.RVALID), 32'd1);
        check("dec_r_rresp",  32'(s_axi.RRESP),  32'(DECERR));
        check("dec_r_rdata",  s_axi.RDATA, 32'd0);
        check("dec_r_noreq",  32'(read_request_o), 32'd0);
        s_axi.RREADY = 1'b1;
        tick();
        s_axi.RREADY = 1'b0;
        check("dec_r_rvalid_clr", 32'(s_axi.RVALID), 32'd0);
        check("dec_r_req_count",  32'(rreq_cnt), 32'd0);

        // ---- read offset 0x10 with back-end error ----
        s_axi.ARADDR = 32'h1000_0010; s_axi.ARVALID = 1'b1;
        tick();
        s_axi.ARVALID = 1'b0;
        check("r1_req",     32'(read_request_o), 32'd1);
        check("r1_addr",    read_address_o, 32'h0000_0010);
        check("r1_arready", 32'(s_axi.ARREADY), 32'd0);
        tick();
        read_done_i = 1'b1; read_error_i = 1'b1; read_data_i = 32'h0000_1234;
        tick();
        read_done_i = 1'b0; read_error_i = 1'b0; read_data_i = 32'h5555_5555;
        check("r1_rvalid", 32'(s_axi.RVALID), 32'd1);
        check("r1_rdata",  s_axi.RDATA, 32'h0000_1234);
        check("r1_rresp",  32'(s_axi.RRESP), 32'(SLVERR));
        tick();
        check("r1_rdata_hold", s_axi.RDATA, 32'h0000_1234);
        check("r1_rvalid_hold", 32'(s_axi.RVALID), 32'd1);
        s_axi.RREADY = 1'b1;
        tick();
        s_axi.RREADY = 1'b0;
        check("r1_rvalid_clr", 32'(s_axi.RVALID), 32'd0);

        // ---- read timeout: no done for 16 wait cycles ----
        s_axi.ARADDR = 32'h1000_0020; s_axi.ARVALID = 1'b1;
        tick();
        s_axi.ARVALID = 1'b0;
        tick();
        tick(15);
        check("to_rvalid_early", 32'(s_axi.RVALID), 32'd0);
        tick();
        check("to_rvalid", 32'(s_axi.RVALID), 32'd1);
        check("to_rresp",  32'(s_axi.RRESP), 32'(SLVERR));
        check("to_rdata",  s_axi.RDATA, 32'd0);
        check("to_req_count", 32'(rreq_cnt), 32'd2);
        s_axi.RREADY = 1'b1;
        tick();
        s_axi.RREADY = 1'b0;

        // ---- concurrent read and write, back ends answer together ----
        s_axi.AWADDR = 32'h1000_0040; s_axi.AWVALID = 1'b1;
        s_axi.WDATA = 32'hA5A5_A5A5; s_axi.WSTRB = 4'hC; s_axi.WVALID = 1'b1;
        s_axi.ARADDR = 32'h1000_0044; s_axi.ARVALID = 1'b1;
        tick();
        s_axi.AWVALID = 1'b0; s_axi.WVALID = 1'b0; s_axi.ARVALID = 1'b0;
        check("cc_wreq",  32'(write_request_o), 32'd1);
        check("cc_rreq",  32'(read_request_o), 32'd1);
        check("cc_waddr", write_address_o, 32'h0000_0040);
        check("cc_raddr", read_address_o, 32'h0000_0044);
        tick();
        write_done_i = 1'b1;
        read_done_i = 1'b1; read_data_i = 32'hCAFE_F00D;
        tick();
        write_done_i = 1'b0; read_done_i = 1'b0; read_data_i = '0;
        check("cc_bvalid", 32'(s_axi.BVALID), 32'd1);
        check("cc_bresp",  32'(s_axi.BRESP), 32'(OKAY));
        check("cc_rvalid", 32'(s_axi.RVALID), 32'd1);
        check("cc_rdata",  s_axi.RDATA, 32'hCAFE_F00D);
        check("cc_rresp",  32'(s_axi.RRESP), 32'(OKAY));
        s_axi.BREADY = 1'b1;
        tick();
        s_axi.BREADY = 1'b0;
        check("cc_bvalid_clr", 32'(s_axi.BVALID), 32'd0);
        check("cc_rvalid_held", 32'(s_axi.RVALID), 32'd1);
        s_axi.RREADY = 1'b1;
        tick();
        s_axi.RREADY = 1'b0;
        check("cc_rvalid_clr", 32'(s_axi.RVALID), 32'd0);
        check("cc_req_count", 32'(rreq_cnt), 32'd3);

        // ---- reset while the write waits on the back end ----
        s_axi.AWADDR = 32'h1000_0050; s_axi.AWVALID = 1'b1;
        s_axi.WDATA = 32'h0000_0050; s_axi.WSTRB = 4'hF; s_axi.WVALID = 1'b1;
        tick();
        s_axi.AWVALID = 1'b0; s_axi.WVALID = 1'b0;
        tick();
        bv_snap = bvalid_cnt;
        rst_i = 1'b1;
        #1;
        check("mrst_awready", 32'(s_axi.AWREADY), 32'd0);
        check("mrst_wready",  32'(s_axi.WREADY), 32'd0);
        tick(2);
        rst_i = 1'b0;
        write_done_i = 1'b1;
        tick();
        write_done_i = 1'b0;
        tick();
        check("mrst_bvalid",    32'(s_axi.BVALID), 32'd0);
        check("mrst_bv_count",  32'(bvalid_cnt - bv_snap), 32'd0);
        check("mrst_awready_up", 32'(s_axi.AWREADY), 32'd1);
        s_axi.AWADDR = 32'h1000_0060; s_axi.AWVALID = 1'b1;
        s_axi.WDATA = 32'h0000_0060; s_axi.WVALID = 1'b1;
        tick();
        s_axi.AWVALID = 1'b0; s_axi.WVALID = 1'b0;
        check("mrst_new_req",  32'(write_request_o), 32'd1);
        check("mrst_new_addr", write_address_o, 32'h0000_0060);
        tick();
        write_done_i = 1'b1;
        tick();
        write_done_i = 1'b0;
        check("mrst_new_bvalid", 32'(s_axi.BVALID), 32'd1);
        check("mrst_new_bresp",  32'(s_axi.BRESP), 32'(OKAY));
        s_axi.BREADY = 1'b1;
        tick();
        s_axi.BREADY = 1'b0;
        check("mrst_new_bvalid_clr", 32'(s_axi.BVALID), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
